// File: rtl/hazard5_fetch_ahbl_if.sv
// Fetch frontend request/response and AHB-Lite master signals of the fetch unit.
// master = fetch unit view, slave = frontend/bus/testbench view.
interface hazard5_fetch_ahbl_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   logic [W_ADDR-1:0] mem_addr;
   logic              mem_addr_vld;
   logic              mem_size;
   logic              mem_addr_rdy;
   logic [W_DATA-1:0] mem_data;
   logic              mem_data_vld;
   logic              mem_data_err;
   logic [W_ADDR-1:0] err_addr;

   logic [W_ADDR-1:0] haddr;
   logic [1:0]        htrans;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [3:0]        hprot;
   logic              hmastlock;
   logic              hwrite;
   logic              hready;
   logic              hresp;
   logic [W_DATA-1:0] hrdata;

   modport master (
      input  mem_addr, mem_addr_vld, mem_size, hready, hresp, hrdata,
      output mem_addr_rdy, mem_data, mem_data_vld, mem_data_err, err_addr,
             haddr, htrans, hsize, hburst, hprot, hmastlock, hwrite
   );

   modport slave (
      output mem_addr, mem_addr_vld, mem_size, hready, hresp, hrdata,
      input  mem_addr_rdy, mem_data, mem_data_vld, mem_data_err, err_addr,
             haddr, htrans, hsize, hburst, hprot, hmastlock, hwrite
   );
endinterface

// File: rtl/hazard5_fetch_ahbl.sv
// Instruction fetch AHB-Lite master: one outstanding data phase, pipelined NONSEQ.
// Define HAZARD5_FETCH_BUSERR_EN to report bus errors (mem_data_err, err_addr).
module hazard5_fetch_ahbl #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
) (
   input logic                 clk,
   input logic                 rst,
   hazard5_fetch_ahbl_if.master bus
);

   logic              dph_vld;
   logic [W_ADDR-1:0] dph_addr;

   // Address phase is purely combinational from the frontend request.
   assign bus.htrans       = (bus.mem_addr_vld && !rst) ? 2'b10 : 2'b00;
   assign bus.haddr        = bus.mem_addr;
   assign bus.hsize        = bus.mem_size ? 3'd2 : 3'd1;
   assign bus.hburst       = 3'b000;
   assign bus.hprot        = 4'b0010;
   assign bus.hmastlock    = 1'b0;
   assign bus.hwrite       = 1'b0;
   assign bus.mem_addr_rdy = bus.mem_addr_vld && bus.hready && !rst;

   // Gating with rst drops any data phase that was in flight when reset hit.
   assign bus.mem_data_vld = dph_vld && bus.hready && !rst;
   assign bus.mem_data     = bus.hrdata;

   always_ff @(posedge clk) begin
      if (rst)
         dph_vld <= 1'b0;
      else if (bus.mem_addr_rdy)
         dph_vld <= 1'b1;
      else if (bus.hready)
         dph_vld <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (bus.mem_addr_rdy)
         dph_addr <= bus.mem_addr;
   end

`ifdef HAZARD5_FETCH_BUSERR_EN
   logic [W_ADDR-1:0] err_addr_q;

   assign bus.mem_data_err = bus.mem_data_vld && bus.hresp;
   assign bus.err_addr     = err_addr_q;

   always_ff @(posedge clk) begin
      if (rst)
         err_addr_q <= '0;
      else if (bus.mem_data_err)
         err_addr_q <= dph_addr;
   end
`else
   // Errors complete as ordinary data; the faulting address is not kept.
   logic unused_err_path;
   assign unused_err_path  = ^{dph_addr, bus.hresp};
   assign bus.mem_data_err = 1'b0;
   assign bus.err_addr     = '0;
`endif

endmodule

// File: tb/tb_hazard5_fetch_ahbl.sv
// Bench for hazard5_fetch_ahbl: directed literal checks plus randomized traffic
// compared each cycle against a queue-based transaction model.
module tb_hazard5_fetch_ahbl;

`ifdef HAZARD5_FETCH_BUSERR_EN
   localparam bit BUSERR = 1'b1;
`else
   localparam bit BUSERR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   bit   chk_en = 1'b0;

   hazard5_fetch_ahbl_if #(.W_ADDR(32), .W_DATA(32)) bus ();

   hazard5_fetch_ahbl #(.W_ADDR(32), .W_DATA(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: fetches accepted but not yet completed, plus last errored address.
   logic [31:0] pend[$];
   logic [31:0] err_m = '0;
   logic        e_rdy, e_dv, e_de;

   always @(negedge clk) begin
      if (chk_en) begin
         e_rdy = bus.mem_addr_vld && bus.hready && !rst;
         e_dv  = (pend.size() != 0) && bus.hready && !rst;
         e_de  = BUSERR && e_dv && bus.hresp;
         chk("htrans", {30'b0, bus.htrans}, (bus.mem_addr_vld && !rst) ? 32'd2 : 32'd0);
         chk("haddr", bus.haddr, bus.mem_addr);
         chk("hsize", {29'b0, bus.hsize}, bus.mem_size ? 32'd2 : 32'd1);
         chk("hctrl", {20'b0, bus.hburst, bus.hprot, bus.hmastlock, bus.hwrite}, 32'h0000_0008);
         chk("rdy", {31'b0, bus.mem_addr_rdy}, {31'b0, e_rdy});
         chk("data_vld", {31'b0, bus.mem_data_vld}, {31'b0, e_dv});
         chk("data_err", {31'b0, bus.mem_data_err}, {31'b0, e_de});
         chk("mem_data", bus.mem_data, bus.hrdata);
         chk("err_addr", bus.err_addr, err_m);
         if (rst) begin
            pend.delete();
            err_m = '0;
         end else begin
            if (e_de) err_m = pend[0];
            if (e_dv) void'(pend.pop_front());
            if (e_rdy) pend.push_back(bus.mem_addr);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [31:0] a, input logic sz,
                      input logic rdy, input logic resp, input logic [31:0] d);
      bus.mem_addr_vld = v;
      bus.mem_addr     = a;
      bus.mem_size     = sz;
      bus.hready       = rdy;
      bus.hresp        = resp;
      bus.hrdata       = d;
   endtask

   logic        rdy_seen;
   int          err_stage;
   logic [31:0] ra;

   initial begin
      drv(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 32'h0);
      // Reset held two cycles with a pending request.
      for (int i = 0; i < 2; i++) begin
         mid();
         chk("rst_htrans", {30'b0, bus.htrans}, 32'd0);
         chk("rst_rdy", {31'b0, bus.mem_addr_rdy}, 32'd0);
         tick();
         chk_en = 1'b1;
      end
      rst = 1'b0;
      drv(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
      mid();
      chk("post_rst_dv", {31'b0, bus.mem_data_vld}, 32'd0);
      chk("post_rst_erraddr", bus.err_addr, 32'd0);
      tick();

      // Back-to-back words 0x0, 0x4, 0x8.
      drv(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 32'hDEAD_0000);
      mid();
      chk("b2b_htrans0", {30'b0, bus.htrans}, 32'd2);
      chk("b2b_hsize0", {29'b0, bus.hsize}, 32'd2);
      chk("b2b_dv0", {31'b0, bus.mem_data_vld}, 32'd0);
      tick();
      drv(1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 32'h1111_0000);
      mid();
      chk("b2b_dv1", {31'b0, bus.mem_data_vld}, 32'd1);
      chk("b2b_data1", bus.mem_data, 32'h1111_0000);
      chk("b2b_haddr1", bus.haddr, 32'h4);
      tick();
      drv(1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 32'h2222_0004);
      mid();
      chk("b2b_dv2", {31'b0, bus.mem_data_vld}, 32'd1);
      chk("b2b_data2", bus.mem_data, 32'h2222_0004);
      tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h3333_0008);
      mid();
      chk("b2b_dv3", {31'b0, bus.mem_data_vld}, 32'd1);
      chk("b2b_data3", bus.mem_data, 32'h3333_0008);
      chk("b2b_idle", {30'b0, bus.htrans}, 32'd0);
      tick();
      mid();
      chk("b2b_dv4", {31'b0, bus.mem_data_vld}, 32'd0);
      tick();

      // Halfword at 0x102 with two wait states.
      drv(1'b1, 32'h102, 1'b0, 1'b1, 1'b0, 32'h0);
      mid();
      chk("hw_haddr", bus.haddr, 32'h102);
      chk("hw_hsize", {29'b0, bus.hsize}, 32'd1);
      chk("hw_rdy", {31'b0, bus.mem_addr_rdy}, 32'd1);
      tick();
      for (int i = 0; i < 2; i++) begin
         drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
         mid();
         chk("hw_wait_dv", {31'b0, bus.mem_data_vld}, 32'd0);
         tick();
      end
      drv(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hABCD_0000);
      mid();
      chk("hw_dv", {31'b0, bus.mem_data_vld}, 32'd1);
      chk("hw_data", bus.mem_data, 32'hABCD_0000);
      tick();
      mid();
      chk("hw_dv_once", {31'b0, bus.mem_data_vld}, 32'd0);
      tick();

      // ERROR response on fetch 0x40; 0x44 accepted in the second error cycle.
      drv(1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 32'h0);
      mid();
      chk("err_rdy40", {31'b0, bus.mem_addr_rdy}, 32'd1);
      tick();
      drv(1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 32'h0);
      mid();
      chk("err1_dv", {31'b0, bus.mem_data_vld}, 32'd0);
      chk("err1_rdy", {31'b0, bus.mem_addr_rdy}, 32'd0);
      tick();
      drv(1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 32'h5555_5555);
      mid();
      chk("err2_dv", {31'b0, bus.mem_data_vld}, 32'd1);
      chk("err2_err", {31'b0, bus.mem_data_err}, {31'b0, BUSERR});
      chk("err2_rdy44", {31'b0, bus.mem_addr_rdy}, 32'd1);
      tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h6666_6666);
      mid();
      chk("err_addr40", bus.err_addr, BUSERR ? 32'h40 : 32'h0);
      chk("dv44", {31'b0, bus.mem_data_vld}, 32'd1);
      chk("err44", {31'b0, bus.mem_data_err}, 32'd0);
      tick();

      // Reset during a data phase with wait states.
      drv(1'b1, 32'h60, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      for (int i = 0; i < 2; i++) begin
         drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
         tick();
      end
      rst = 1'b1;
      mid();
      chk("rstmid_dv", {31'b0, bus.mem_data_vld}, 32'd0);
      chk("rstmid_htrans", {30'b0, bus.htrans}, 32'd0);
      tick();
      rst = 1'b0;
      drv(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h7777_7777);
      for (int i = 0; i < 2; i++) begin
         mid();
         chk("rstmid_after_dv", {31'b0, bus.mem_data_vld}, 32'd0);
         tick();
      end
      drv(1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 32'h0);
      mid();
      chk("fresh_rdy", {31'b0, bus.mem_addr_rdy}, 32'd1);
      chk("fresh_erraddr", bus.err_addr, 32'd0);
      tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h8888_0080);
      mid();
      chk("fresh_dv", {31'b0, bus.mem_data_vld}, 32'd1);
      chk("fresh_data", bus.mem_data, 32'h8888_0080);
      rdy_seen = 1'b0;
      tick();

      // Randomized traffic: frontend holds requests until accepted; slave
      // inserts wait states and two-cycle ERROR responses.
      err_stage = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!(bus.mem_addr_vld && !rdy_seen)) begin
            bus.mem_addr_vld = ($urandom_range(0, 2) != 0);
            bus.mem_size     = $urandom_range(0, 1) == 1;
            ra               = $urandom;
            bus.mem_addr     = bus.mem_size ? (ra & 32'hFFFF_FFFC) : (ra & 32'hFFFF_FFFE);
         end
         if (err_stage == 1) begin
            bus.hready = 1'b1;
            bus.hresp  = 1'b1;
            err_stage  = 0;
         end else if (pend.size() != 0 && $urandom_range(0, 7) == 0) begin
            bus.hready = 1'b0;
            bus.hresp  = 1'b1;
            err_stage  = 1;
         end else begin
            bus.hready = ($urandom_range(0, 3) != 0);
            bus.hresp  = 1'b0;
         end
         bus.hrdata = $urandom;
         rst = ($urandom_range(0, 63) == 0);
         if (rst) err_stage = 0;
         mid();
         rdy_seen = bus.mem_addr_rdy;
         tick();
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard5_fetch_ahbl.md
HAZARD5_FETCH_AHBL -- requirements
Module: hazard5_fetch_ahbl

Interface
REQ-001 SHALL have parameter W_ADDR, default 32: fetch address width; only 32 is supported.
REQ-002 SHALL have parameter W_DATA, default 32: fetch data width; only 32 is supported.
REQ-003 SHALL have ports: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports: mem_addr  input  W_ADDR  fetch address from frontend.
REQ-006 SHALL have ports: mem_addr_vld  input  1  fetch request; addr/size held stable until the cycle after mem_addr_rdy.
REQ-007 SHALL have ports: mem_size  input  1  1 = word, 0 = halfword.
REQ-008 SHALL have ports: mem_addr_rdy  output  1  address phase accepted this cycle.
REQ-009 SHALL have ports: mem_data  output  W_DATA  fetch data, byte lanes as on bus.
REQ-010 SHALL have ports: mem_data_vld  output  1  a data phase completes this cycle.
REQ-011 SHALL have ports: mem_data_err  output  1  the completing data phase was an ERROR response.
REQ-012 SHALL have ports: err_addr  output  W_ADDR  address of the most recent errored fetch.
REQ-013 SHALL have ports: haddr  output  W_ADDR; htrans  output  2; hsize  output  3; hburst  output  3; hprot  output  4; hmastlock  output  1; hwrite  output  1: AHB-Lite master address phase.
REQ-014 SHALL have ports: hready  input  1; hresp  input  1; hrdata  input  W_DATA: AHB-Lite master response.

Function
REQ-015 SHALL drive htrans=NONSEQ (2'b10) when mem_addr_vld && !rst, else IDLE (2'b00).
REQ-016 SHALL drive haddr=mem_addr, hsize=3'd2 if mem_size else 3'd1, hburst=3'b000, hprot=4'b0010, hmastlock=0, hwrite=0, all combinationally.
REQ-017 SHALL assign mem_addr_rdy = mem_addr_vld && hready && !rst.
REQ-018 SHALL hold register dph_vld; it loads 1 when mem_addr_rdy and loads 0 when hready && !mem_addr_rdy.
REQ-019 SHALL assign mem_data_vld = dph_vld && hready, giving data latency of one cycle after acceptance plus bus wait states.
REQ-020 SHALL pass hrdata to mem_data unmodified; halfword data at address bit 1 = 1 arrives in bits [31:16].
REQ-021 SHALL support at most one outstanding data phase, with back-to-back NONSEQ allowed: address N+1 accepted in the same cycle data N completes.
REQ-022 SHALL register the accepted address into dph_addr on mem_addr_rdy.
REQ-023 SHALL hold dph_vld and dph_addr during wait states (hready=0).
REQ-024 SHALL treat the first ERROR cycle (dph_vld, hready=0, hresp=1) as a wait state.
REQ-025 SHALL complete an ERROR response on its second cycle (hready=1, hresp=1) with mem_data_vld=1, and that completion SHALL count as exactly one data phase.
REQ-026 SHALL accept an address presented during the second ERROR cycle normally; no cancellation to IDLE.
REQ-027 SHALL drive mem_data_vld=0 and mem_data_err=0 whenever dph_vld=0, irrespective of hready/hresp.
REQ-028 SHALL NOT gate any output on mem_data_vld, and hready SHALL NOT feed any state other than dph_vld, dph_addr and err_addr.

Reset
REQ-029 SHALL clear dph_vld and err_addr to 0 in any cycle rst=1.
REQ-030 SHALL force htrans=IDLE and mem_addr_rdy=0 in any cycle rst=1.
REQ-031 SHALL abandon without reporting a data phase in flight when rst asserts: mem_data_vld=0 while rst=1 and in the first cycle after rst deasserts.
REQ-032 SHALL leave dph_addr unreset.

Configuration
REQ-033 SHALL use macro HAZARD5_FETCH_BUSERR_EN to select error reporting.
REQ-034 SHALL, when HAZARD5_FETCH_BUSERR_EN is defined, drive mem_data_err = mem_data_vld && hresp.
REQ-035 SHALL, when HAZARD5_FETCH_BUSERR_EN is defined, load err_addr from dph_addr on that cycle.
REQ-036 SHALL, when HAZARD5_FETCH_BUSERR_EN is not defined, tie mem_data_err=0 and err_addr=0, and an ERROR completes as ordinary data with identical timing.

Verification
REQ-037 SHALL cover: rst high 2 cycles with mem_addr_vld=1 -> htrans=IDLE, mem_addr_rdy=0; first cycle after release: mem_data_vld=0.
REQ-038 SHALL cover: back-to-back word fetches at 0x0, 0x4, 0x8 with hready=1 -> three NONSEQ cycles, hsize=2; mem_data_vld=1 on cycles 2-4 with hrdata passed through.
REQ-039 SHALL cover: halfword fetch at 0x102 -> haddr=0x102, hsize=1; two wait states -> mem_data_vld exactly once, 3 cycles after acceptance.
REQ-040 SHALL cover: with BUSERR_EN, fetch at 0x40 answered ERROR (hready 0/1, hresp 1/1) -> single mem_data_vld with mem_data_err=1, err_addr=0x40; next fetch at 0x44 accepted in second error cycle.
REQ-041 SHALL cover: without BUSERR_EN, same stimulus -> mem_data_err=0, err_addr=0, identical mem_data_vld timing.
REQ-042 SHALL cover: rst asserted during a 3-wait-state data phase -> no mem_data_vld afterwards; dph_vld=0; fresh fetch at 0x80 behaves as after power-on.
